// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and helpers for the floor request scheduler:
//                car state encoding, direction constants, floor index width.
//  Revision    : 1.0  initial release
// ============================================================================
package elevator_pkg;

    // Car sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Width of a floor index for an n-stop car (never narrower than one bit)
    function automatic int floor_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floor_request_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_scheduler_if
//  Description : Button/LED and car-status bundle between the call panel
//                (master) and the request scheduler (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface floor_request_scheduler_if #(
    parameter int FLOORS = 4
) ();
    import elevator_pkg::*;

    localparam int FW = floor_w(FLOORS);

    logic [FLOORS-1:0] call_req;
    logic [FLOORS-1:0] pending;
    logic [FW-1:0]     cur_floor;
    logic              dir_up;
    logic              moving;
    logic              door_open;
    logic              arrive;

    // Call panel side: drives buttons, observes LEDs and car status
    modport master (
        output call_req,
        input  pending, cur_floor, dir_up, moving, door_open, arrive
    );

    // Scheduler side
    modport slave (
        input  call_req,
        output pending, cur_floor, dir_up, moving, door_open, arrive
    );

endinterface
`default_nettype wire

// File: rtl/floor_timer.sv
`default_nettype none
// ============================================================================
//  Module      : floor_timer
//  Description : Loadable down-counter. Stops at zero; done flags the last
//                cycle of an interval (count == 1).
//  Revision    : 1.0  initial release
// ============================================================================
module floor_timer #(
    parameter int W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load,
    input  wire logic [W-1:0] load_val,
    output logic              done
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // Next count: load wins, otherwise decrement until zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : floor_request_scheduler
//  Description : SCAN (collective) elevator scheduler. Latches calls into a
//                pending mask, keeps direction while calls remain ahead,
//                reverses otherwise, and sequences hop / door intervals.
//  Revision    : 1.0  initial release
// ============================================================================
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 4,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    floor_request_scheduler_if.slave  bus
);

    localparam int FW     = floor_w(FLOORS);
    localparam int MAX_CY = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW     = $clog2(MAX_CY + 1);

    state_t            state_d,     state_q;
    logic [FLOORS-1:0] pending_d,   pending_q;
    logic [FW-1:0]     cur_floor_d, cur_floor_q;
    logic              dir_up_d,    dir_up_q;
    logic              arrive_d,    arrive_q;

    logic [FLOORS-1:0] clr;
    logic [FW-1:0]     next_floor;
    logic [FLOORS-1:0] ahead_now;
    logic [FLOORS-1:0] behind_now;
    logic [FLOORS-1:0] ahead_next;
    logic              hop_load;
    logic              door_load;
    logic              hop_done;
    logic              door_done;

    // Floors strictly above (up=1) or strictly below (up=0) floor f
    function automatic logic [FLOORS-1:0] side_mask(input logic [FW-1:0] f, input logic up);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    floor_timer #(.W(TW)) u_hop_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hop_load),
        .load_val (TW'(TRAVEL_CYCLES)),
        .done     (hop_done)
    );

    floor_timer #(.W(TW)) u_door_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (door_load),
        .load_val (TW'(DOOR_CYCLES)),
        .done     (door_done)
    );

    // Next-state, car position/direction, timer loads and call latch
    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        arrive_d    = 1'b0;
        hop_load    = 1'b0;
        door_load   = 1'b0;
        clr         = '0;

        next_floor = dir_up_q ? (cur_floor_q + FW'(1)) : (cur_floor_q - FW'(1));
        ahead_now  = pending_q & side_mask(cur_floor_q, dir_up_q);
        behind_now = pending_q & side_mask(cur_floor_q, ~dir_up_q);
        ahead_next = pending_q & side_mask(next_floor, dir_up_q);

        case (state_q)
            IDLE: begin
                if (pending_q[cur_floor_q]) begin
                    state_d   = DOOR;
                    door_load = 1'b1;
                end else if (ahead_now != '0) begin
                    state_d  = MOVING;
                    hop_load = 1'b1;
                end else if (behind_now != '0) begin
                    dir_up_d = ~dir_up_q;
                    state_d  = MOVING;
                    hop_load = 1'b1;
                end
            end
            MOVING: begin
                if (hop_done) begin
                    cur_floor_d = next_floor;
                    arrive_d    = 1'b1;
                    if (pending_q[next_floor]) begin
                        state_d   = DOOR;
                        door_load = 1'b1;
                    end else if (ahead_next != '0) begin
                        hop_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR: begin
                // A same-floor call while open restarts the full door interval
                if (bus.call_req[cur_floor_q]) begin
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Door opening or open: the served floor's call is cleared/absorbed
        if ((state_q == DOOR) || (state_d == DOOR)) begin
            clr[cur_floor_d] = 1'b1;
        end
        pending_d = (pending_q | bus.call_req) & ~clr;
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            cur_floor_q <= '0;
            dir_up_q    <= UP;
            arrive_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            arrive_q    <= arrive_d;
        end
    end

    assign bus.pending   = pending_q;
    assign bus.cur_floor = cur_floor_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.moving    = (state_q == MOVING);
    assign bus.door_open = (state_q == DOOR);
    assign bus.arrive    = arrive_q;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floor_request_scheduler
//  Description : Directed scoreboard bench for floor_request_scheduler.
//                Stimulus queues expected car events; a monitor pops and
//                compares them as arrive / hop-end / door edges appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_floor_request_scheduler;

    localparam int FLOORS = 4;
    localparam int TRAVEL = 8;
    localparam int DOORC  = 16;
    localparam int BUDGET = 2000;

    localparam int EV_ARR    = 0;
    localparam int EV_MEND   = 1;
    localparam int EV_DOPEN  = 2;
    localparam int EV_DCLOSE = 3;

    typedef struct {
        int kind;
        int floor;
        int aux;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ev_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    logic prev_door = 1'b0;
    logic prev_mov  = 1'b0;
    int   door_cnt  = 0;
    int   mov_cnt   = 0;

    floor_request_scheduler_if #(.FLOORS(FLOORS)) bus ();

    floor_request_scheduler #(
        .FLOORS        (FLOORS),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOORC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, req);
    endtask

    task automatic push(input int k, input int f, input int a);
        ev_t e;
        e.kind  = k;
        e.floor = f;
        e.aux   = a;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int f, input int a);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got kind %0d floor %0d aux %0d, expected none", k, f, a);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            if (k == e.kind) begin
                case (k)
                    EV_ARR:    begin chk("arrive_floor", f, e.floor); chk("arrive_dir", a, e.aux); end
                    EV_DOPEN:  begin chk("door_floor", f, e.floor); chk("door_pending_bit", a, e.aux); end
                    EV_MEND:   chk("hop_cycles", a, e.aux);
                    default:   chk("door_cycles", a, e.aux);
                endcase
            end
        end
    endtask

    // Monitor: turns DUT output edges into events for the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_door = 1'b0;
                prev_mov  = 1'b0;
                door_cnt  = 0;
                mov_cnt   = 0;
            end else begin
                if (bus.arrive) observe(EV_ARR, int'(bus.cur_floor), int'(bus.dir_up));
                if (prev_mov && !bus.moving) observe(EV_MEND, 0, mov_cnt);
                if (!prev_door && bus.door_open)
                    observe(EV_DOPEN, int'(bus.cur_floor), int'(bus.pending[bus.cur_floor]));
                if (prev_door && !bus.door_open) observe(EV_DCLOSE, 0, door_cnt);
                mov_cnt   = bus.moving ? (prev_mov ? mov_cnt + 1 : 1) : 0;
                door_cnt  = bus.door_open ? (prev_door ? door_cnt + 1 : 1) : 0;
                prev_mov  = bus.moving;
                prev_door = bus.door_open;
            end
        end
    end

    task automatic pulse(input logic [FLOORS-1:0] v);
        @(negedge clk);
        bus.call_req = v;
        @(negedge clk);
        bus.call_req = '0;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        bus.call_req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_pending"},   int'(bus.pending),   0);
        chk({nm, "_cur_floor"}, int'(bus.cur_floor), 0);
        chk({nm, "_dir_up"},    int'(bus.dir_up),    1);
        chk({nm, "_moving"},    int'(bus.moving),    0);
        chk({nm, "_door_open"}, int'(bus.door_open), 0);
        chk({nm, "_arrive"},    int'(bus.arrive),    0);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !bus.moving && !bus.door_open) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_in_budget"}, int'(n < BUDGET), 1);
    endtask

    task automatic wait_door(input string nm);
        int n;
        n = 0;
        while (!bus.door_open && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_door_in_budget"}, int'(n < BUDGET), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.call_req = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Call at the current floor: door cycle only
        push(EV_DOPEN, 0, 0);
        push(EV_DCLOSE, 0, DOORC);
        @(negedge clk);
        bus.call_req = 4'b0001;
        @(negedge clk);
        chk("s1_pending_latched", int'(bus.pending), 1);
        bus.call_req = '0;
        wait_idle("s1");
        chk("s1_pending_cleared", int'(bus.pending), 0);

        // Floor 0 to 3 in three back-to-back hops
        push(EV_ARR, 1, 1);
        push(EV_ARR, 2, 1);
        push(EV_ARR, 3, 1);
        push(EV_MEND, 0, 3 * TRAVEL);
        push(EV_DOPEN, 3, 0);
        push(EV_DCLOSE, 0, DOORC);
        pulse(4'b1000);
        wait_idle("s2");
        chk("s2_floor", int'(bus.cur_floor), 3);
        chk("s2_dir", int'(bus.dir_up), 1);

        // Call for a floor being passed: stop at 1, then continue to 3
        apply_reset();
        push(EV_ARR, 1, 1);
        push(EV_MEND, 0, TRAVEL);
        push(EV_DOPEN, 1, 0);
        push(EV_DCLOSE, 0, DOORC);
        push(EV_ARR, 2, 1);
        push(EV_ARR, 3, 1);
        push(EV_MEND, 0, 2 * TRAVEL);
        push(EV_DOPEN, 3, 0);
        push(EV_DCLOSE, 0, DOORC);
        pulse(4'b1000);
        repeat (2) @(negedge clk);
        pulse(4'b0010);
        wait_idle("s3");
        chk("s3_floor", int'(bus.cur_floor), 3);

        // At 2 going up with 1001 pending: serve 3, reverse, serve 0
        apply_reset();
        push(EV_ARR, 1, 1);
        push(EV_ARR, 2, 1);
        push(EV_MEND, 0, 2 * TRAVEL);
        push(EV_DOPEN, 2, 0);
        push(EV_DCLOSE, 0, DOORC);
        push(EV_ARR, 3, 1);
        push(EV_MEND, 0, TRAVEL);
        push(EV_DOPEN, 3, 0);
        push(EV_DCLOSE, 0, DOORC);
        push(EV_ARR, 2, 0);
        push(EV_ARR, 1, 0);
        push(EV_ARR, 0, 0);
        push(EV_MEND, 0, 3 * TRAVEL);
        push(EV_DOPEN, 0, 0);
        push(EV_DCLOSE, 0, DOORC);
        pulse(4'b0100);
        wait_door("s4");
        pulse(4'b1001);
        chk("s4_pending_1001", int'(bus.pending), 9);
        wait_idle("s4");
        chk("s4_floor", int'(bus.cur_floor), 0);
        chk("s4_dir_down", int'(bus.dir_up), 0);

        // Door reopen at floor 2: call at door cycle 10 gives 10+16 cycles
        push(EV_ARR, 1, 1);
        push(EV_ARR, 2, 1);
        push(EV_MEND, 0, 2 * TRAVEL);
        push(EV_DOPEN, 2, 0);
        push(EV_DCLOSE, 0, 10 + DOORC);
        pulse(4'b0100);
        wait_door("s5");
        repeat (9) @(negedge clk);
        bus.call_req = 4'b0100;
        @(negedge clk);
        bus.call_req = '0;
        chk("s5_call_absorbed", int'(bus.pending), 0);
        wait_idle("s5");
        chk("s5_pending_after", int'(bus.pending), 0);

        // Asynchronous reset mid-hop
        apply_reset();
        push(EV_ARR, 1, 1);
        pulse(4'b1000);
        n = 0;
        while (bus.cur_floor != 2'd1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reached_1", int'(n < BUDGET), 1);
        repeat (2) @(negedge clk);
        chk("s6_pending_mid", int'(bus.pending), 8);
        chk("s6_moving_mid", int'(bus.moving), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("s6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_reset("s6_hold");
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_request_scheduler.md
# floor_request_scheduler

Clocked, parametrised elevator request scheduler for a FLOORS-stop car. It latches hall/car calls into a pending mask and drives the call LEDs. It serves calls in SCAN (collective) order: it keeps its direction while calls remain ahead, then reverses. Internal hop and door timers sequence the car, and the block sits between the button/LED layer and the motor/door drivers.

## Interface
- FLOORS, 4, number of stops; legal range 2..16.
- TRAVEL_CYCLES, 8, clock cycles per one-floor hop; must be ≥1.
- DOOR_CYCLES, 16, clock cycles the door stays open; must be ≥1.
- FW, derived localparam, $clog2(FLOORS), floor index width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- call_req  in  FLOORS  call buttons; bit i = call for floor i; level or pulse.
- pending  out  FLOORS  latched unserved calls; doubles as call LEDs.
- cur_floor  out  FW  floor the car is at, or last floor passed.
- dir_up  out  1  current travel direction; 1 = up.
- moving  out  1  car is in a hop.
- door_open  out  1  door open command.
- arrive  out  1  one-cycle pulse when cur_floor updates.

## Operation
- Reset: state IDLE, pending=0, cur_floor=0, dir_up=1, moving=0, door_open=0, arrive=0, timers=0.
- Call latch, every cycle: pending <= (pending | call_req) & ~clr.
  - clr is a one-hot of cur_floor, asserted in any cycle where the door opens or is open.
- ahead = pending bits strictly above cur_floor when dir_up=1, strictly below when dir_up=0.
- behind = pending bits strictly on the opposite side.
- States:
  - IDLE: evaluate in this order.
    - pending[cur_floor]: go to DOOR, load door timer.
    - ahead≠0: go to MOVING, load hop timer, dir unchanged.
    - behind≠0: toggle dir_up, go to MOVING, load hop timer.
    - else stay in IDLE.
  - MOVING: moving=1, hop timer counts down. When it reaches 1:
    - step cur_floor ±1 and pulse arrive.
    - if pending at the new floor: go to DOOR.
    - elif calls remain ahead of the new floor: reload the hop timer and stay in MOVING.
    - else go to IDLE.
  - DOOR: door_open=1, door timer counts down.
    - A call_req for cur_floor is absorbed (never reaches pending) and reloads the door timer (reopen).
    - When the door timer reaches 1, go to IDLE.
- A car in IDLE never reverses while ahead≠0. Calls arriving behind the car wait for the reversal.
- cur_floor saturates by construction: a hop is only started toward an existing pending floor, so the car never passes 0 or FLOORS-1.
- Calls for floors the car is passing (not yet arrived) stay pending and are served when the car arrives.
- Mid-operation reset returns every output to its reset value asynchronously. Pending calls are lost.

## Timing
- call_req sampled at edge k appears on pending after edge k.
- The IDLE decision uses registered pending, so moving/door_open rise after edge k+1: latency 2 edges from press to action.
- moving stays high exactly TRAVEL_CYCLES cycles per hop.
- Back-to-back hops keep moving high continuously. cur_floor and arrive update on the final edge of each hop.
- Stop at the new floor: moving falls and door_open rises on the same edge as the cur_floor update.
- door_open stays high exactly DOOR_CYCLES cycles, plus a full reload per same-floor call.
- From IDLE with pending[cur_floor], door_open rises 1 edge after the bit is seen. The pending bit clears on that same edge.
- All outputs are registered. The block has no combinational input-to-output path.

## Structure
- elevator_pkg holds:
  - state enum (IDLE, MOVING, DOOR).
  - floor_w(n) helper function.
  - direction constants UP=1, DOWN=0.
- Sub-module floor_timer: loadable down-counter with load, load value, and done=(count==1) outputs.
  - Instantiated twice, once for the hop timer and once for the door timer.
  - Counter width is $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1).

## Test plan
All scenarios use FLOORS=4, TRAVEL_CYCLES=8, DOOR_CYCLES=16.
- Reset, then pulse call_req=4'b0001 at floor 0 → pending=0001 for 1 cycle, then door_open high for 16 cycles, pending=0, state back to IDLE.
- Call floor 3 from floor 0 → moving high 24 cycles, arrive pulses at floors 1, 2, 3, door_open rises with cur_floor=3, dir_up=1.
- Car moving up from floor 0 toward 3, with call floor 1 pressed before the first hop ends → stop at 1 (door 16 cycles), then continue to 3.
- At floor 2 going up with pending=1001 → serve 3 first, then dir_up toggles to 0 and the car serves 0.
- Door open at floor 2, call_req=0100 pulsed at door cycle 10 → door_open lasts 10+16 cycles and pending[2] never sets.
- rst_n low mid-hop (cur_floor=1, pending=1000) → all outputs return to reset values immediately and stay there until the next call.
